vedic8x8_seq_mult: RTL and testbench



---
 rtl/vedic8x8_seq_mult_if.sv | 22 ++
 rtl/vedic8x8_seq_mult.sv | 152 +++++++++++++++
 tb/tb_vedic8x8_seq_mult.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vedic8x8_seq_mult_if.sv
// Operand/product handshake bundle for vedic8x8_seq_mult.
// Master drives operands and out_ready; slave (the multiplier) returns the product.
interface vedic8x8_seq_mult_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/vedic8x8_seq_mult.sv
// Sequential 8x8 unsigned Vedic multiplier: one 4x4 partial product and one 12-bit add per cycle.
// Optional macro VEDIC_ZERO_BYPASS_EN: a zero operand skips the four multiply steps.
module vedic8x8_seq_mult #(
    parameter int W     = 8,
    parameter int ACC_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vedic8x8_seq_mult_if.slave    bus,
    output logic [1:0]            o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits for ready, and an offered product holds stable until taken.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [ACC_W-1:0]   r_acc;
    logic [1:0]         r_step;
    logic [3:0]         r_p0_lo;
    logic [2*W-1:0]     r_product;
    logic               r_out_valid;
    logic               r_zero;
    logic               w_zero_op;
    logic [3:0]         w_nib_a;
    logic [3:0]         w_nib_b;
    logic [7:0]         w_pp;
    logic [ACC_W-1:0]   w_term;
    logic [ACC_W-1:0]   w_sum;

    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] r;
        logic       c;
        r[0] = x[0] & y[0];
        r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c    = x[1] & y[0] & x[0] & y[1];
        r[2] = (x[1] & y[1]) ^ c;
        r[3] = x[1] & y[1] & c;
        return r;
    endfunction

    // Urdhva-Tiryagbhyam: vertical and crosswise 2x2 products, summed at their weights.
    function automatic logic [7:0] vedic4x4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic2x2(x[1:0], y[1:0]);
        q1 = vedic2x2(x[3:2], y[1:0]);
        q2 = vedic2x2(x[1:0], y[3:2]);
        q3 = vedic2x2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

`ifdef VEDIC_ZERO_BYPASS_EN
    assign w_zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign w_zero_op = 1'b0;
`endif

    // step[0] picks the a nibble, step[1] the b nibble: p0, p1, p2, p3 in order.
    assign w_nib_a = r_step[0] ? r_a[7:4] : r_a[3:0];
    assign w_nib_b = r_step[1] ? r_b[7:4] : r_b[3:0];
    assign w_pp    = vedic4x4(w_nib_a, w_nib_b);

    always_comb begin
        w_term = '0;
        case (r_step)
            2'd0:    w_term = {8'b0, w_pp[7:4]};
            2'd1,
            2'd2:    w_term = {4'b0, w_pp};
            default: w_term = {w_pp, 4'b0};
        endcase
    end

    assign w_sum = r_acc + w_term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next_state = S_MUL;
            S_MUL:   if (r_zero || (r_step == 2'd3)) w_next_state = S_DONE;
            S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.busy      = (r_state == S_MUL) && !r_zero;
        bus.out_valid = r_out_valid;
        bus.product   = r_product;
        o_dbg_state   = r_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_step      <= '0;
            r_p0_lo     <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_acc  <= '0;
                        r_step <= '0;
                        r_zero <= w_zero_op;
                    end
                end
                S_MUL: begin
                    if (r_zero) begin
                        r_product   <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_acc  <= w_sum;
                        r_step <= r_step + 2'd1;
                        if (r_step == 2'd0) r_p0_lo <= w_pp[3:0];
                        if (r_step == 2'd3) begin
                            r_product   <= {w_sum, r_p0_lo};
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic8x8_seq_mult.sv
// Self-checking bench for vedic8x8_seq_mult: directed table, hand sequences and random operands
// against a plain a*b reference with latency/busy derived from the operation rules.
module tb_vedic8x8_seq_mult;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] dbg_state;

    vedic8x8_seq_mult_if bus ();

    vedic8x8_seq_mult dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

`ifdef VEDIC_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          hold;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
        return (BYPASS && (a == 8'd0 || b == 8'd0)) ? 1 : 4;
    endfunction

    function automatic int exp_busy(input logic [7:0] a, input logic [7:0] b);
        return (BYPASS && (a == 8'd0 || b == 8'd0)) ? 0 : 4;
    endfunction

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    // One full operation: accept, count cycles to out_valid, optional backpressure, release.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int hold);
        int lat;
        int bcnt;
        logic [15:0] held;
        exp_q.push_back(exp);
        bus.out_ready = (hold == 0);
        wait_in_ready();
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.a = 8'($urandom_range(0, 255));
        bus.b = 8'($urandom_range(0, 255));
        lat = 0;
        bcnt = 0;
        while (!bus.out_valid && lat < 20) begin
            bcnt += int'(bus.busy);
            if (bus.in_ready) check("in_ready_low_while_mul", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(lat), 32'(exp_latency(a, b)));
        check("busy_cycles", 32'(bcnt), 32'(exp_busy(a, b)));
        check("product", 32'(bus.product), 32'(exp_q.pop_front()));
        held = bus.product;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_product", 32'(bus.product), 32'(held));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{a: 8'h12, b: 8'h34, exp: 16'h03A8, hold: 0};
        vecs[1] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01, hold: 0};
        vecs[2] = '{a: 8'h0F, b: 8'hF0, exp: 16'h0E10, hold: 0};
        vecs[3] = '{a: 8'hA5, b: 8'h3C, exp: 16'h26AC, hold: 10};
        vecs[4] = '{a: 8'h00, b: 8'hC3, exp: 16'h0000, hold: 0};
        vecs[5] = '{a: 8'h80, b: 8'h01, exp: 16'h0080, hold: 2};

        // Reset held three edges while a request is offered.
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 8'h55;
        bus.b = 8'h66;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_product", 32'(bus.product), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_reset_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
        end

        // Reset sampled at the second multiply step aborts the operation.
        wait_in_ready();
        bus.in_valid = 1'b1;
        bus.a = 8'h77;
        bus.b = 8'h99;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midop_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midop_reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("midop_reset_product", 32'(bus.product), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("midop_no_out_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        run_op(8'h02, 8'h03, 16'h0006, 0);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = 8'd0;
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            run_op(ra, rb, {8'b0, ra} * {8'b0, rb}, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
